// File: rtl/cq_parser.sv
// CQ (completer request) parser for a 256-bit PCIe AXI-Stream interface.
// Decodes the request descriptor on the sop beat, issues memory writes/reads
// to the user side, and holds completion context until the completion is sent.
// Optional statistics counters are built when CQ_PARSER_STATS_EN is defined.
module cq_parser #(
    parameter int unsigned DATA_WIDTH = 256
) (
    input  logic                  user_clk,
    input  logic                  user_rst_n,
    input  logic [DATA_WIDTH-1:0] m_axis_cq_tdata,
    input  logic                  m_axis_cq_tvalid,
    input  logic                  m_axis_cq_tlast,
    output logic [21:0]           m_axis_cq_tready,
    input  logic [84:0]           m_axis_cq_tuser,
    output logic [63:0]           req_addr,
    output logic [10:0]           req_dword_count,
    output logic [3:0]            req_first_be,
    output logic [3:0]            req_last_be,
    output logic                  wr_valid,
    output logic [127:0]          wr_data,
    input  logic                  wr_ready,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [15:0]           cpl_requester_id,
    output logic [7:0]            cpl_tag,
    output logic [2:0]            cpl_tc,
    output logic [6:0]            cpl_lower_addr,
    output logic [2:0]            cpl_status,
    output logic                  cpl_err_valid,
    input  logic                  cpl_done,
    output logic [31:0]           stat_req_count,
    output logic [15:0]           stat_drop_count
);

    typedef enum logic [2:0] {StIdle, StWrIssue, StRdIssue, StCplWait, StDrain} state_e;
    // Action decided on the sop beat, executed immediately or after DRAIN.
    typedef enum logic [1:0] {ActWr, ActRd, ActCpl, ActDrop} act_e;

    localparam logic [2:0] CplOk = 3'b000;  // successful completion
    localparam logic [2:0] CplUr = 3'b001;  // unsupported request
    localparam logic [2:0] CplCa = 3'b100;  // completer abort

    state_e       state_q, state_d;
    act_e         act_q, act_new;
    logic         tready_q;
    logic         wr_valid_q, rd_valid_q, cpl_err_valid_q;
    logic [63:0]  addr_q;
    logic [10:0]  dw_count_q;
    logic [3:0]   first_be_q, last_be_q;
    logic [127:0] wr_data_q;
    logic [15:0]  rid_q;
    logic [7:0]   tag_q;
    logic [2:0]   tc_q;
    logic [6:0]   lower_addr_q;
    logic [2:0]   cpl_status_q, cpl_status_d, status_new;

    logic [3:0]   req_type;
    logic [10:0]  dw_count;
    logic [3:0]   first_be;
    logic         len_ok;
    logic         sop_beat, junk_beat, drain_last;
    logic [1:0]   be_off;

    assign req_type   = m_axis_cq_tdata[78:75];
    assign dw_count   = m_axis_cq_tdata[74:64];
    assign first_be   = m_axis_cq_tuser[3:0];
    assign len_ok     = (dw_count != 11'd0) && (dw_count <= 11'd4);
    assign sop_beat   = (state_q == StIdle) && m_axis_cq_tvalid && tready_q
                        && m_axis_cq_tuser[40];
    assign junk_beat  = (state_q == StIdle) && m_axis_cq_tvalid && tready_q
                        && !m_axis_cq_tuser[40];
    assign drain_last = (state_q == StDrain) && m_axis_cq_tvalid && tready_q
                        && m_axis_cq_tlast;

    function automatic state_e act_state(input act_e act);
        case (act)
            ActWr:   return StWrIssue;
            ActRd:   return StRdIssue;
            ActCpl:  return StCplWait;
            default: return StIdle;
        endcase
    endfunction

    // Classify the request type; messages (11xx) and MemWr are posted, all else non-posted.
    always_comb begin
        act_new    = ActCpl;
        status_new = CplOk;
        case (req_type)
            4'b0000: begin
                if (len_ok) begin
                    act_new = ActRd;
                end else begin
                    status_new = CplCa;
                end
            end
            4'b0001:                            act_new = len_ok ? ActWr : ActDrop;
            4'b1100, 4'b1101, 4'b1110, 4'b1111: act_new = ActDrop;
            default:                            status_new = CplUr;
        endcase
    end

    // Lowest enabled byte in first_be gives the byte offset for the lower address.
    always_comb begin
        be_off = 2'd0;
        casez (first_be)
            4'b???1: be_off = 2'd0;
            4'b??10: be_off = 2'd1;
            4'b?100: be_off = 2'd2;
            4'b1000: be_off = 2'd3;
            default: be_off = 2'd0;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_d      = state_q;
        cpl_status_d = sop_beat ? status_new : cpl_status_q;
        case (state_q)
            StIdle: begin
                if (sop_beat) state_d = m_axis_cq_tlast ? act_state(act_new) : StDrain;
            end
            StDrain:   if (drain_last) state_d = act_state(act_q);
            StWrIssue: if (wr_ready) state_d = StIdle;
            StRdIssue: if (rd_ready) state_d = StCplWait;
            StCplWait: if (cpl_done) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // State and registered handshake/flag outputs, all derived from the next state.
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            state_q         <= StIdle;
            tready_q        <= 1'b0;
            wr_valid_q      <= 1'b0;
            rd_valid_q      <= 1'b0;
            cpl_err_valid_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            tready_q        <= (state_d == StIdle) || (state_d == StDrain);
            wr_valid_q      <= (state_d == StWrIssue);
            rd_valid_q      <= (state_d == StRdIssue);
            cpl_err_valid_q <= (state_d == StCplWait) && (cpl_status_d != CplOk);
        end
    end

    // Descriptor capture on the sop beat; fields hold until the next request.
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            act_q        <= ActDrop;
            addr_q       <= '0;
            dw_count_q   <= '0;
            first_be_q   <= '0;
            last_be_q    <= '0;
            wr_data_q    <= '0;
            rid_q        <= '0;
            tag_q        <= '0;
            tc_q         <= '0;
            lower_addr_q <= '0;
            cpl_status_q <= CplOk;
        end else if (sop_beat) begin
            act_q        <= act_new;
            addr_q       <= {m_axis_cq_tdata[63:2], 2'b00};
            dw_count_q   <= dw_count;
            first_be_q   <= first_be;
            last_be_q    <= m_axis_cq_tuser[7:4];
            wr_data_q    <= m_axis_cq_tdata[255:128];
            rid_q        <= m_axis_cq_tdata[95:80];
            tag_q        <= m_axis_cq_tdata[103:96];
            tc_q         <= m_axis_cq_tdata[123:121];
            lower_addr_q <= {m_axis_cq_tdata[6:2], be_off};
            cpl_status_q <= status_new;
        end
    end

`ifdef CQ_PARSER_STATS_EN
    logic [31:0] req_cnt_q;
    logic [15:0] drop_cnt_q;
    logic        drop_event;

    assign drop_event = junk_beat || (sop_beat && (act_new == ActDrop));

    // Request counter wraps; drop counter saturates.
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            req_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (sop_beat) req_cnt_q <= req_cnt_q + 32'd1;
            if (drop_event && (drop_cnt_q != 16'hFFFF)) drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign stat_req_count  = req_cnt_q;
    assign stat_drop_count = drop_cnt_q;
`else
    logic unused_junk;
    assign unused_junk     = junk_beat;
    assign stat_req_count  = '0;
    assign stat_drop_count = '0;
`endif

    assign m_axis_cq_tready = {22{tready_q}};
    assign req_addr         = addr_q;
    assign req_dword_count  = dw_count_q;
    assign req_first_be     = first_be_q;
    assign req_last_be      = last_be_q;
    assign wr_valid         = wr_valid_q;
    assign wr_data          = wr_data_q;
    assign rd_valid         = rd_valid_q;
    assign cpl_requester_id = rid_q;
    assign cpl_tag          = tag_q;
    assign cpl_tc           = tc_q;
    assign cpl_lower_addr   = lower_addr_q;
    assign cpl_status       = cpl_status_q;
    assign cpl_err_valid    = cpl_err_valid_q;

    // Descriptor/sideband bits this block does not decode.
    logic unused_bits;
    assign unused_bits = ^{m_axis_cq_tuser[84:41], m_axis_cq_tuser[39:8],
                           m_axis_cq_tdata[1:0], m_axis_cq_tdata[79],
                           m_axis_cq_tdata[120:104], m_axis_cq_tdata[127:124]};

endmodule
